// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA constants, slot encodings and helpers
package vga_pkg;

  // Four-phase RAM slot schedule; even slots prefer the scan-out path
  typedef enum logic [1:0] {
    SLOT_VGA0 = 2'd0,
    SLOT_CPU1 = 2'd1,
    SLOT_VGA2 = 2'd2,
    SLOT_CPU3 = 2'd3
  } slot_e;

  localparam int FB_WORDS_640x480 = 153600;
  localparam int PIX_W            = 8;
  localparam int WORD_W           = 16;

  // 640x480@60 timing, shared with the timing generator
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  function automatic logic is_vga_slot(input slot_e s);
    return (s == SLOT_VGA0) || (s == SLOT_VGA2);
  endfunction

endpackage

// File: rtl/vga_pix_fifo.sv
// rtl/vga_pix_fifo.sv - prefetch FIFO holding fetched framebuffer words
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              Clk50,
  input  logic              Reset,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [WORD_W-1:0] head,
  output logic [CW-1:0]     count,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Data array write; contents need no reset since count gates visibility
  always_ff @(posedge Clk50) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties the queue and wins over push/pop
  always_ff @(posedge Clk50) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter between VGA scan-out and CPU
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int               ADDR_W      = 18,
  parameter logic [ADDR_W-1:0] FB_BASE    = '0,
  parameter int               FB_WORDS    = FB_WORDS_640x480,
  parameter int               FIFO_DEPTH  = 4,
  parameter logic [7:0]       UFLOW_COLOR = 8'hE0
) (
  input  logic              Clk50,
  input  logic              Reset,
  input  logic              PClk,
  input  logic              Active,
  input  logic              VSync,
  output logic [7:0]        Pixel,
  output logic              Underrun,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [15:0]       CpuWData,
  output logic              CpuAck,
  output logic [15:0]       CpuRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWe,
  output logic [15:0]       MemWData,
  input  logic [15:0]       MemRData
);

  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_LVL = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] WORDS_LIM = (ADDR_W+1)'(FB_WORDS);

  slot_e             slot;
  logic [ADDR_W-1:0] fetch_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   word_cnt;
  logic              rd_vga_q;
  logic              cpu_rd_q;
  logic              byte_sel;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [15:0]       fifo_head;
  logic [CW:0]       level;
  logic              vga_want;
  logic              vga_issue;
  logic              cpu_grant;
  logic              consume;
  logic              push;
  logic              pop;

  // Words buffered plus the one possibly in flight must fit the FIFO
  assign level     = {1'b0, fifo_count} + {{CW{1'b0}}, rd_vga_q};
  assign vga_want  = VSync && (level < DEPTH_LVL) && (word_cnt < WORDS_LIM);
  assign vga_issue = !Reset && is_vga_slot(slot) && vga_want;
  // Ack cycle blocks a re-grant so a still-held request is served once
  assign cpu_grant = !Reset && CpuReq && !CpuAck && !vga_issue;
  assign consume   = PClk && Active && VSync;
  // A return landing during VSync low belongs to the previous frame
  assign push      = rd_vga_q && VSync;
  assign pop       = consume && byte_sel && !fifo_empty;

  // RAM port mux: VGA fetch, CPU grant, or hold the last address idle
  always_comb begin
    MemAddr  = addr_q;
    MemWe    = 1'b0;
    MemWData = '0;
    if (vga_issue) begin
      MemAddr = fetch_ptr;
    end else if (cpu_grant) begin
      MemAddr  = CpuAddr;
      MemWe    = CpuWe;
      MemWData = CpuWData;
    end
  end

  assign CpuRData = (CpuAck && cpu_rd_q) ? MemRData : '0;

  // Slot counter, held address and one-cycle tags for reads in flight
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      slot     <= SLOT_VGA0;
      addr_q   <= '0;
      rd_vga_q <= 1'b0;
      CpuAck   <= 1'b0;
      cpu_rd_q <= 1'b0;
    end else begin
      slot     <= slot_e'(slot + 2'd1);
      addr_q   <= MemAddr;
      rd_vga_q <= vga_issue;
      CpuAck   <= cpu_grant;
      cpu_rd_q <= cpu_grant && !CpuWe;
    end
  end

  // Fetch pointer and word count; rewound for every frame while VSync is low
  always_ff @(posedge Clk50) begin
    if (Reset || !VSync) begin
      fetch_ptr <= FB_BASE;
      word_cnt  <= '0;
    end else if (vga_issue) begin
      fetch_ptr <= fetch_ptr + 1'b1;
      word_cnt  <= word_cnt + 1'b1;
    end
  end

  // Pixel serialiser: low byte then high byte of the FIFO head
  always_ff @(posedge Clk50) begin
    if (Reset) begin
      Pixel    <= '0;
      byte_sel <= 1'b0;
      Underrun <= 1'b0;
    end else begin
      if (PClk) begin
        Pixel <= !consume   ? 8'h00 :
                 fifo_empty ? UFLOW_COLOR :
                 byte_sel   ? fifo_head[15:8] : fifo_head[7:0];
      end
      if (!VSync) begin
        byte_sel <= 1'b0;
        Underrun <= 1'b0;
      end else if (consume) begin
        byte_sel <= ~byte_sel;
        if (fifo_empty) Underrun <= 1'b1;
      end
    end
  end

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .Clk50     (Clk50),
    .Reset     (Reset),
    .push      (push),
    .push_data (MemRData),
    .pop       (pop),
    .flush     (!VSync),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule
